// File: rtl/mpmc10_app_wdf_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : mpmc10_app_wdf_burst_gen
// Purpose  : Multi-beat MIG write-data FIFO driver (app_wdf_wren/end/data/
//            mask). A burst is triggered from the controller WRITE_DATA0
//            state, and all outputs are held stable under app_wdf_rdy
//            backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module mpmc10_app_wdf_burst_gen #(
    parameter int         WID         = 128,
    parameter int         MAX_BEATS   = 4,
    parameter int         END_MODE    = 0,
    parameter int         BW          = $clog2(MAX_BEATS + 1),
    // Encoding of WRITE_DATA0 in the controller state package. It must match
    // the mpmc10_pkg value used by the instantiating controller.
    parameter logic [3:0] WRITE_DATA0 = 4'd6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         state,
    input  logic               rdy,
    input  logic [BW-1:0]      nbeats,
    input  logic [WID-1:0]     dat_i,
    input  logic [WID/8-1:0]   sel_i,
    output logic [BW-1:0]      beat_o,
    output logic               wren,
    output logic               wend,
    output logic [WID-1:0]     data,
    output logic [WID/8-1:0]   mask,
    output logic               busy,
    output logic               done,
    output logic [15:0]        stall_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [BW-1:0] c_max_beats = BW'(MAX_BEATS);
    localparam logic [BW-1:0] c_one       = BW'(1);
    // When set, every beat is its own app_wdf_end (4:1 MIG with BL8).
    localparam logic          c_end_every = (END_MODE != 0);
    localparam logic [15:0]   c_stall_max = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    fsm_t             fsm_q,   fsm_d;
    logic [BW-1:0]    n_q,     n_d;      // effective beat count of this burst
    logic [BW-1:0]    beat_q,  beat_d;   // index of the beat the next load samples
    logic             wren_q,  wren_d;
    logic             wend_q,  wend_d;
    logic [WID-1:0]   data_q,  data_d;
    logic [WID/8-1:0] mask_q,  mask_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [15:0]      stall_q, stall_d;

    // ------------------------------------------------------------------------
    // Helper terms
    // ------------------------------------------------------------------------
    logic [BW-1:0] n_eff;       // nbeats with 0 / out-of-range mapped to MAX_BEATS
    logic          trigger;     // controller sits in WRITE_DATA0
    logic          accept;      // beat on the bus is taken by the MIG this edge
    logic          last_beat;   // beat on the bus is the final one of the burst
    logic [BW-1:0] beat_inc;

    // Decode the trigger, the acceptance handshake and the burst length.
    always_comb begin
        n_eff     = nbeats;
        if ((nbeats == '0) || (nbeats > c_max_beats)) begin
            n_eff = c_max_beats;
        end
        trigger   = (state == WRITE_DATA0);
        accept    = wren_q && rdy;
        // beat_q already points one past the beat on the bus, so the bus
        // carries the last beat (index N-1) exactly when beat_q equals N.
        last_beat = (beat_q == n_q);
        beat_inc  = beat_q + c_one;
    end

    // Next-state and output logic of the burst FSM.
    always_comb begin
        fsm_d   = fsm_q;
        n_d     = n_q;
        beat_d  = beat_q;
        wren_d  = wren_q;
        wend_d  = wend_q;
        data_d  = data_q;
        mask_d  = mask_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        stall_d = stall_q;

        case (fsm_q)
            ST_IDLE: begin
                if (trigger) begin
                    // Beat 0 is loaded on the trigger edge itself, so wren
                    // rises the cycle after WRITE_DATA0 is first seen.
                    n_d     = n_eff;
                    data_d  = dat_i;
                    mask_d  = ~sel_i;
                    wren_d  = 1'b1;
                    wend_d  = c_end_every || (n_eff == c_one);
                    busy_d  = 1'b1;
                    beat_d  = c_one;
                    stall_d = '0;
                    fsm_d   = ST_XFER;
                end
            end

            ST_XFER: begin
                // The controller state is ignored here: a started burst
                // always runs to completion.
                if (accept) begin
                    if (last_beat) begin
                        wren_d = 1'b0;
                        wend_d = 1'b0;
                        done_d = 1'b1;
                        busy_d = 1'b0;
                        beat_d = '0;
                        fsm_d  = ST_DONE;
                    end else begin
                        // Present beat index beat_q; it is the final beat
                        // when the index after it equals N.
                        data_d = dat_i;
                        mask_d = ~sel_i;
                        beat_d = beat_inc;
                        wend_d = c_end_every || (beat_inc == n_q);
                    end
                end else if (stall_q != c_stall_max) begin
                    // wren is always high in XFER, so no accept means the
                    // MIG is back-pressuring this beat.
                    stall_d = stall_q + 16'd1;
                end
            end

            ST_DONE: begin
                // Wait for the controller to leave WRITE_DATA0 so that a
                // single long WRITE_DATA0 dwell cannot launch a second burst.
                if (!trigger) begin
                    fsm_d = ST_IDLE;
                end
            end

            default: begin
                fsm_d  = ST_IDLE;
                wren_d = 1'b0;
                wend_d = 1'b0;
                busy_d = 1'b0;
                beat_d = '0;
            end
        endcase
    end

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            n_q     <= c_max_beats;
            beat_q  <= '0;
            wren_q  <= 1'b0;
            wend_q  <= 1'b0;
            data_q  <= '0;
            mask_q  <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            n_q     <= n_d;
            beat_q  <= beat_d;
            wren_q  <= wren_d;
            wend_q  <= wend_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            stall_q <= stall_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from flops
    // ------------------------------------------------------------------------
    assign beat_o    = beat_q;
    assign wren      = wren_q;
    assign wend      = wend_q;
    assign data      = data_q;
    assign mask      = mask_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign stall_cnt = stall_q;

endmodule
`default_nettype wire
